// File: rtl/spi_mcu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : spi_mcu_pkg
// Brief    : Shared state encodings, framing constants and helpers for the
//            NDN<->MCU serial link (rx deframer and tx serialiser).
// Revision : 1.0 - initial release
// ============================================================================
package spi_mcu_pkg;

    // Receive-side FSM states
    typedef enum logic [2:0] {
        R_IDLE = 3'd0,
        R_HDR  = 3'd1,
        R_LEN  = 3'd2,
        R_PFX  = 3'd3,
        R_PAR  = 3'd4,
        R_END  = 3'd5
    } rx_state_t;

    // Transmit-side FSM states
    typedef enum logic [2:0] {
        T_IDLE  = 3'd0,
        T_START = 3'd1,
        T_HDR   = 3'd2,
        T_PFX   = 3'd3,
        T_DATA  = 3'd4,
        T_PAR   = 3'd5,
        T_END   = 3'd6,
        T_GAP   = 3'd7
    } tx_state_t;

    // Framing constants
    localparam logic PKT_INTEREST = 1'b1;
    localparam logic PKT_DATA     = 1'b0;
    localparam logic START_BIT    = 1'b0;
    localparam logic END_BIT      = 1'b0;
    localparam logic IDLE_LINE    = 1'b1;

    // Larger of two integers, used to size shared field counters
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_mcu_tx_ser.sv
`default_nettype none
// ============================================================================
// Module   : spi_mcu_tx_ser
// Brief    : Transmit serialiser. Accepts one data packet over a valid/ready
//            handshake and shifts start, filler, type, prefix, payload,
//            optional parity, end and gap bits onto miso, MSB first.
// Options  : SPI_MCU_LINK_PARITY_EN - insert an even-parity bit over type,
//            prefix and payload ahead of the end bit.
// Revision : 1.0 - initial release
// ============================================================================
module spi_mcu_tx_ser
    import spi_mcu_pkg::*;
#(
    parameter int PREFIX_W   = 64,
    parameter int DATA_BYTES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic [PREFIX_W-1:0]     tx_prefix,
    input  logic [DATA_BYTES*8-1:0] tx_data,
    output logic                    miso
);

    localparam int DATA_W = DATA_BYTES * 8;
    localparam int SR_W   = PREFIX_W + DATA_W;
    localparam int CNT_W  = $clog2(max2(max2(PREFIX_W, DATA_W), 2));

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PFX_LAST  = CNT_W'(PREFIX_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic             FILLER    = 1'b0;

    tx_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    // Prefix and payload sit back to back so one shifter covers both fields
    logic [SR_W-1:0]    r_sr;
`ifdef SPI_MCU_LINK_PARITY_EN
    logic               r_par;
`endif

    // Transmit FSM: miso is registered and always shows the bit of the current state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= T_IDLE;
            r_cnt    <= '0;
            r_sr     <= '0;
            miso     <= IDLE_LINE;
            tx_ready <= 1'b1;
`ifdef SPI_MCU_LINK_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            case (r_state)
                T_IDLE: begin
                    miso <= IDLE_LINE;
                    if (tx_valid && tx_ready) begin
                        r_sr     <= {tx_prefix, tx_data};
`ifdef SPI_MCU_LINK_PARITY_EN
                        // Type bit is 0, so it adds nothing to the parity
                        r_par    <= ^{tx_prefix, tx_data};
`endif
                        tx_ready <= 1'b0;
                        miso     <= START_BIT;
                        r_state  <= T_START;
                    end
                end
                T_START: begin
                    miso    <= FILLER;
                    r_cnt   <= CNT_ONE;
                    r_state <= T_HDR;
                end
                T_HDR: begin
                    // cnt=1 while the filler is out, cnt=0 while the type is out
                    if (r_cnt != '0) begin
                        miso  <= PKT_DATA;
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        miso    <= r_sr[SR_W-1];
                        r_sr    <= {r_sr[SR_W-2:0], 1'b0};
                        r_cnt   <= PFX_LAST;
                        r_state <= T_PFX;
                    end
                end
                T_PFX: begin
                    miso <= r_sr[SR_W-1];
                    r_sr <= {r_sr[SR_W-2:0], 1'b0};
                    if (r_cnt == '0) begin
                        r_cnt   <= DATA_LAST;
                        r_state <= T_DATA;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                T_DATA: begin
                    if (r_cnt == '0) begin
`ifdef SPI_MCU_LINK_PARITY_EN
                        miso    <= r_par;
                        r_state <= T_PAR;
`else
                        miso    <= END_BIT;
                        r_state <= T_END;
`endif
                    end else begin
                        miso  <= r_sr[SR_W-1];
                        r_sr  <= {r_sr[SR_W-2:0], 1'b0};
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                T_PAR: begin
                    miso    <= END_BIT;
                    r_state <= T_END;
                end
                T_END: begin
                    miso    <= IDLE_LINE;
                    r_state <= T_GAP;
                end
                T_GAP: begin
                    miso     <= IDLE_LINE;
                    tx_ready <= 1'b1;
                    r_state  <= T_IDLE;
                end
                default: begin
                    miso     <= IDLE_LINE;
                    tx_ready <= 1'b1;
                    r_state  <= T_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_mcu_link.sv
`default_nettype none
// ============================================================================
// Module   : spi_mcu_link
// Brief    : NDN-side slave of the NDN<->MCU serial link. Deframes interest
//            packets from mosi into a held valid/ready output towards the PIT
//            and serialises PIT data packets onto miso. Framing, chip-select
//            abort, overrun and parity failures raise a one-cycle rx_err.
// Options  : SPI_MCU_LINK_PARITY_EN - even-parity bit in both directions.
// Revision : 1.0 - initial release
// ============================================================================
module spi_mcu_link
    import spi_mcu_pkg::*;
#(
    parameter int PREFIX_W   = 64,
    parameter int LEN_W      = 6,
    parameter int DATA_BYTES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mosi,
    input  logic                    cs,
    output logic                    miso,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [LEN_W-1:0]        rx_length,
    output logic [PREFIX_W-1:0]     rx_prefix,
    output logic                    rx_err,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic [PREFIX_W-1:0]     tx_prefix,
    input  logic [DATA_BYTES*8-1:0] tx_data
);

    localparam int RX_CNT_W = $clog2(max2(max2(LEN_W, PREFIX_W), 2));

    localparam logic [RX_CNT_W-1:0] RX_CNT_ONE  = RX_CNT_W'(1);
    localparam logic [RX_CNT_W-1:0] RX_LEN_LAST = RX_CNT_W'(LEN_W - 1);
    localparam logic [RX_CNT_W-1:0] RX_PFX_LAST = RX_CNT_W'(PREFIX_W - 1);

    rx_state_t              r_rx_state;
    logic [RX_CNT_W-1:0]    r_rx_cnt;
    logic                   r_rx_type;
    logic [LEN_W-1:0]       r_rx_len;
    logic [PREFIX_W-1:0]    r_rx_pfx;
    logic                   w_rx_par_err;

`ifdef SPI_MCU_LINK_PARITY_EN
    // Running XOR of type, length, prefix and parity bit; even parity leaves 0
    logic                   r_rx_par;
    assign w_rx_par_err = r_rx_par;
`else
    assign w_rx_par_err = 1'b0;
`endif

    // Receive FSM: deframes mosi, holds the PIT-side outputs and pulses rx_err
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= R_IDLE;
            r_rx_cnt   <= '0;
            r_rx_type  <= 1'b0;
            r_rx_len   <= '0;
            r_rx_pfx   <= '0;
            rx_valid   <= 1'b0;
            rx_length  <= '0;
            rx_prefix  <= '0;
            rx_err     <= 1'b0;
`ifdef SPI_MCU_LINK_PARITY_EN
            r_rx_par   <= 1'b0;
`endif
        end else begin
            rx_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if ((r_rx_state != R_IDLE) && cs) begin
                // Master dropped the frame: give up without touching held outputs
                r_rx_state <= R_IDLE;
                rx_err     <= 1'b1;
            end else begin
                case (r_rx_state)
                    R_IDLE: begin
                        if (!cs && (mosi == START_BIT)) begin
                            r_rx_cnt   <= RX_CNT_ONE;
                            r_rx_state <= R_HDR;
`ifdef SPI_MCU_LINK_PARITY_EN
                            r_rx_par   <= 1'b0;
`endif
                        end
                    end
                    R_HDR: begin
                        // First cycle is the don't-care filler, second is the type
                        if (r_rx_cnt != '0) begin
                            r_rx_cnt <= r_rx_cnt - RX_CNT_ONE;
                        end else begin
                            r_rx_type  <= mosi;
`ifdef SPI_MCU_LINK_PARITY_EN
                            r_rx_par   <= r_rx_par ^ mosi;
`endif
                            r_rx_cnt   <= RX_LEN_LAST;
                            r_rx_state <= R_LEN;
                        end
                    end
                    R_LEN: begin
                        r_rx_len <= {r_rx_len[LEN_W-2:0], mosi};
`ifdef SPI_MCU_LINK_PARITY_EN
                        r_rx_par <= r_rx_par ^ mosi;
`endif
                        if (r_rx_cnt == '0) begin
                            r_rx_cnt   <= RX_PFX_LAST;
                            r_rx_state <= R_PFX;
                        end else begin
                            r_rx_cnt <= r_rx_cnt - RX_CNT_ONE;
                        end
                    end
                    R_PFX: begin
                        r_rx_pfx <= {r_rx_pfx[PREFIX_W-2:0], mosi};
`ifdef SPI_MCU_LINK_PARITY_EN
                        r_rx_par <= r_rx_par ^ mosi;
`endif
                        if (r_rx_cnt == '0) begin
`ifdef SPI_MCU_LINK_PARITY_EN
                            r_rx_state <= R_PAR;
`else
                            r_rx_state <= R_END;
`endif
                        end else begin
                            r_rx_cnt <= r_rx_cnt - RX_CNT_ONE;
                        end
                    end
                    R_PAR: begin
`ifdef SPI_MCU_LINK_PARITY_EN
                        r_rx_par   <= r_rx_par ^ mosi;
`endif
                        r_rx_state <= R_END;
                    end
                    R_END: begin
                        r_rx_state <= R_IDLE;
                        if ((mosi != END_BIT) || w_rx_par_err) begin
                            rx_err <= 1'b1;
                        end else if (r_rx_type == PKT_INTEREST) begin
                            if (rx_valid) begin
                                // PIT still owns the previous interest: drop the new one
                                rx_err <= 1'b1;
                            end else begin
                                rx_valid  <= 1'b1;
                                rx_length <= r_rx_len;
                                rx_prefix <= r_rx_pfx;
                            end
                        end
                    end
                    default: begin
                        r_rx_state <= R_IDLE;
                    end
                endcase
            end
        end
    end

    spi_mcu_tx_ser #(
        .PREFIX_W   (PREFIX_W),
        .DATA_BYTES (DATA_BYTES)
    ) u_tx_ser (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_prefix (tx_prefix),
        .tx_data   (tx_data),
        .miso      (miso)
    );

endmodule
`default_nettype wire

// File: doc/spi_mcu_link.md
Name: spi_mcu_link

Overview:
Parametrised successor to the NDN↔MCU serial link. The NDN side is the slave.
- Receives framed interest packets on mosi and delivers length and prefix to the PIT through a valid/ready handshake.
- Serialises data packets from the PIT onto miso through a second valid/ready handshake.
- Compared with the previous generation it adds configurable widths and payload size, an end-bit framing check, chip-select abort, backpressure with overrun detection, and optional parity.

Parameters:
PREFIX_W, 64, prefix width in bits (rx and tx)
LEN_W, 6, interest length field width in bits
DATA_BYTES, 32, tx data payload size in bytes (payload = DATA_BYTES*8 bits)

Ports:
clk  in  1  system clock; one serial bit per rising edge
rst  in  1  asynchronous, active-low reset
mosi  in  1  serial rx line, idles high
cs  in  1  active-low chip select; gates rx only
miso  out  1  serial tx line, idles high
rx_valid  out  1  interest available to PIT
rx_ready  in  1  PIT accepts interest
rx_length  out  LEN_W  received prefix length
rx_prefix  out  PREFIX_W  received prefix
rx_err  out  1  one-cycle pulse: framing, abort, overrun or parity error
tx_valid  in  1  PIT offers data packet
tx_ready  out  1  link can accept packet
tx_prefix  in  PREFIX_W  prefix to send
tx_data  in  DATA_BYTES*8  payload to send; bit [DATA_BYTES*8-1] is sent first

Behaviour:
- Reset (rst low, async): miso=1, rx_valid=0, rx_length=0, rx_prefix=0, rx_err=0, tx_ready=1; both FSMs go to IDLE and all counters clear.
- Rx frame, one bit per clk:
  - start 0, filler X, type (1 = interest), LEN_W length bits MSB first, PREFIX_W prefix bits MSB first, [parity], end bit 0.
- Rx FSM states: R_IDLE → R_HDR (filler + type) → R_LEN → R_PFX → [R_PAR] → R_END → R_IDLE.
  - R_IDLE: a cycle with cs=0 and mosi=0 is the start bit; the FSM goes to R_HDR.
  - Shift registers load MSB first; a down-counter sized by $clog2 of the field width counts each field.
  - R_END, mosi=0, type=1, no parity error, rx_valid=0: latch length and prefix and assert rx_valid on the next cycle.
  - R_END, mosi=0, type=0: discard silently, no error.
  - R_END, mosi=1: discard and pulse rx_err.
  - A valid frame completing while rx_valid=1 is an overrun: discard the new frame, pulse rx_err, keep the held outputs.
  - cs going high in any non-idle rx state: abort to R_IDLE next cycle, pulse rx_err, leave the outputs untouched.
- Rx handshake: rx_valid stays high, with stable outputs, until the cycle rx_ready=1; it drops on the following cycle. Outputs hold their last value after the handshake.
- Tx FSM states: T_IDLE → T_START → T_HDR → T_PFX → T_DATA → [T_PAR] → T_END → T_GAP → T_IDLE.
  - tx_ready=1 only in T_IDLE. On tx_valid && tx_ready, latch prefix and data, drop tx_ready, and go to T_START.
  - The start bit (0) appears on miso the cycle after acceptance.
  - T_HDR: filler 0, then type 0.
  - T_PFX: PREFIX_W bits, MSB first.
  - T_DATA: DATA_BYTES*8 bits, MSB first.
  - T_END: drives 0.
  - T_GAP: drives 1 for one cycle.
  - Total cycles from acceptance to tx_ready high again: 5 + PREFIX_W + DATA_BYTES*8 (+1 with parity).
- Tx and rx run independently; simultaneous activity is legal. cs does not affect tx.
- Async reset mid-frame: both directions abort immediately to reset values; no partial output.

Optional Feature:
SPI_MCU_LINK_PARITY_EN
- Defined:
  - Rx expects an even-parity bit over type, length and prefix before the end bit. On mismatch the frame is discarded and rx_err pulses.
  - Tx inserts an even-parity bit over type, prefix and data before the end bit.
- Undefined: no parity bit in either direction; frame lengths are one bit shorter.

Decomposition:
- Package spi_mcu_pkg holds:
  - the rx and tx state enums
  - the constants PKT_INTEREST=1, PKT_DATA=0, START_BIT=0, END_BIT=0, IDLE_LINE=1
- One natural sub-module: spi_mcu_tx_ser (tx FSM plus shift register). The rx path stays in the top level.

Test Plan:
- Interest, type=1, len=6'h2A, prefix=64'hDEADBEEF_01234567, rx_ready=1 → rx_valid one cycle; rx_length=2A; rx_prefix matches; rx_err=0.
- Same frame with rx_ready=0, then a second frame → first outputs held; rx_err pulses once at the second frame's end bit; after rx_ready the first is consumed.
- Frame whose end bit is 1, and a frame where cs rises mid-prefix → rx_err pulses; rx_valid stays 0.
- tx_prefix=64'h1, tx_data=256'hA5…A5 → miso sequence is 0,0,0, 63 zeros, 1, then A5 bytes MSB first, 0, 1; tx_ready low for exactly 325 cycles.
- Reset asserted mid-tx and mid-rx → miso=1 and rx_valid=0 immediately; a clean frame after release is handled correctly.
- With SPI_MCU_LINK_PARITY_EN: corrupt the parity bit → frame dropped, rx_err pulses; tx inserts the correct parity bit.
